// File: rtl/audio_sample_fifo_if.sv
// Output stream from the sample FIFO to the HDMI audio packetizer.
// The FIFO owns the data/valid/frame signals, and the consumer owns ready.
interface audio_sample_fifo_if #(
    parameter int BIT_WIDTH = 16
);
    logic [BIT_WIDTH-1:0] out_left;
    logic [BIT_WIDTH-1:0] out_right;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           frame_index;
    logic                 block_start;

    modport master (
        output out_left, out_right, out_valid, frame_index, block_start,
        input  out_ready
    );

    modport slave (
        input  out_left, out_right, out_valid, frame_index, block_start,
        output out_ready
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// Captures mono samples with mute/attenuation, buffers them in a FWFT FIFO and
// presents them as L/R pairs while tracking the IEC 60958 channel-status frame.
module audio_sample_fifo #(
    parameter int DEPTH            = 8,
    parameter int BIT_WIDTH        = 16,
    parameter int FRAMES_PER_BLOCK = 192
) (
    input  logic                         clk_pixel,
    input  logic                         reset_n,
    input  logic signed [BIT_WIDTH-1:0]  level,
    input  logic                         level_valid,
    input  logic                         mute,
    input  logic [3:0]                   atten,
    audio_sample_fifo_if.master          out_bus,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         overflow
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FULL_COUNT = FILL_W'(DEPTH);
    localparam logic [7:0]        LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [7:0]           frame_q;

    logic signed [BIT_WIDTH-1:0] shifted;
    logic [BIT_WIDTH-1:0]        stored;
    logic                        full;
    logic                        pop;
    logic                        push;
    logic                        drop;

    // Arithmetic shift keeps the sign, so -32768 >>> 15 is -1 and 32767 >>> 15 is 0.
    assign shifted = level >>> atten;
    assign stored  = mute ? '0 : shifted;

    assign full = (fill == FULL_COUNT);
    assign pop  = out_bus.out_valid && out_bus.out_ready;
    assign push = level_valid && (!full || pop);
    assign drop = level_valid && full && !pop;

    // fill clears asynchronously, so every output derived from it drops
    // to its idle value as soon as reset_n falls.
    assign out_bus.out_valid   = (fill != '0);
    assign out_bus.out_left    = out_bus.out_valid ? mem[rd_ptr] : '0;
    assign out_bus.out_right   = out_bus.out_left;
    assign out_bus.frame_index = frame_q;
    assign out_bus.block_start = out_bus.out_valid && (frame_q == 8'd0);

    // NOTE: sample storage has no reset; the pointers and fill define what is valid.
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem[wr_ptr] <= stored;
        end
    end

    // NOTE: state registers use non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            frame_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                frame_q <= (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Downstream stage of the sine-sample source: captures each 16-bit signed mono audio sample when it is strobed valid and applies mute and attenuation. It buffers samples in a small FIFO and presents them as stereo L/R pairs on a valid/ready interface to the HDMI audio packetizer. It also tracks the 192-frame IEC 60958 channel-status block position so the packetizer can flag block starts.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- BIT_WIDTH, 16, sample width (signed)
- FRAMES_PER_BLOCK, 192, IEC 60958 frames per channel-status block

- clk_pixel  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- level  in  BIT_WIDTH  signed input sample
- level_valid  in  1  one-cycle strobe; level is captured this cycle
- mute  in  1  when high, captured samples are replaced by 0
- atten  in  4  arithmetic right-shift amount applied to captured samples
- out_left  out  BIT_WIDTH  signed left sample (head of FIFO)
- out_right  out  BIT_WIDTH  signed right sample; always equals out_left
- out_valid  out  1  FIFO non-empty, outputs hold a sample
- out_ready  in  1  consumer accepts; pop occurs when out_valid && out_ready
- frame_index  out  8  IEC frame number of the sample currently presented, 0..FRAMES_PER_BLOCK-1
- block_start  out  1  out_valid && frame_index == 0
- fill  out  $clog2(DEPTH+1)  number of stored samples, 0..DEPTH
- overflow  out  1  sticky; set when a valid sample is dropped

## Operation
- Push condition: level_valid && (fill < DEPTH || pop in same cycle).
- Stored value: mute ? 0 : (level >>> atten). Use a sign-preserving arithmetic shift. atten = 15 maps -32768 to -1 and 32767 to 0. mute and atten are sampled in the push cycle only.
- Drop: level_valid while fill == DEPTH and no pop. The sample is discarded, fifo contents are unchanged, and overflow is set to 1. overflow clears only on reset.
- Pop: out_valid && out_ready. The head advances and frame_index increments, wrapping from FRAMES_PER_BLOCK-1 to 0.
- Simultaneous push and pop: both take effect and fill is unchanged. With fill == 0, a push and a pop cannot happen in the same cycle because out_valid is low.
- out_ready while out_valid is low has no effect. frame_index does not advance.
- Pointers are log2(DEPTH) bits and wrap naturally. fill is a separate counter: +1 on push only, -1 on pop only.
- frame_index advances only on pops, never on drops. The block count therefore follows delivered samples.
- Outputs are first-word-fall-through. out_left and out_right are read combinationally from the RAM at the read pointer, and are stable while out_valid is high and no pop occurs.

## Timing
- Reset (reset_n low, asynchronous) forces the following immediately:
  - pointers = 0, fill = 0, out_valid = 0
  - out_left/out_right = 0
  - frame_index = 0, block_start = 0, overflow = 0
  - contents are discarded
- Reset mid-operation drops all stored samples. After reset_n rises, the first pushed sample is presented with frame_index 0.
- Latency: a sample pushed in cycle N is at the outputs with out_valid = 1 in cycle N+1 when the FIFO was empty.
- fill and overflow update at the clock edge following the push, pop or drop.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset/basic: assert reset_n = 0 mid-stream with fill = 3 -> all outputs 0 immediately. Then push 0x1234 -> out_left = out_right = 0x1234, out_valid = 1 one cycle later, frame_index = 0, block_start = 1.
- Attenuation/mute: push -32768 with atten = 15 -> -1. Push 32767 with atten = 15 -> 0. Push 0x4000 with atten = 2 -> 0x1000. Push 0x7FFF with mute = 1 -> 0.
- Full/overflow: out_ready = 0, push DEPTH+2 samples 1..10 -> fill = 8, overflow = 1. Popping then yields 1..8 in order, then out_valid = 0.
- Push at full with pop: fill = 8, level_valid and out_ready both high -> sample accepted, fill stays 8, overflow stays 0.
- Block wrap: stream 400 samples with out_ready = 1 -> block_start pulses on pops 0, 192 and 384. frame_index goes from 191 to 0.
- Backpressure: random out_ready at 30% against a push every 4 cycles -> the output sequence matches the input exactly, with no drops and overflow = 0.
